instr_fetch_prefetch: RTL

Parametrised instruction-fetch unit: the next generation of the single-request fetch stage. It runs ahead of the decoder, fetching sequential instruction words over a Wishbone classic master port into a DEPTH-entry prefetch FIFO. It presents them to decode through a valid/ready handshake and accepts a redirect (branch/jump/trap target) that flushes buffered and in-flight fetches. It sits between the PC/branch logic and the decode stage and replaces the stall-every-fetch behaviour with buffered, back-to-back fetches and bus-error reporting.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/instr_fetch_prefetch_if.sv | 27 ++
 rtl/prefetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_prefetch.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching instruction-fetch unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // One prefetch buffer entry at the default address/data widths.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
    logic                    fault;
  } fetch_entry_t;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/instr_fetch_prefetch_if.sv
// Wishbone classic bus bundle between the fetch unit (master) and memory (slave).
interface instr_fetch_prefetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                      wb_cyc_o;
  logic                      wb_stb_o;
  logic                      wb_ack_i;
  logic                      wb_err_i;
  logic [ADDR_WIDTH-1:0]     wb_adr_o;
  logic [DATA_WIDTH-1:0]     wb_dat_o;
  logic [DATA_WIDTH-1:0]     wb_dat_i;
  logic [DATA_WIDTH/8-1:0]   wb_sel_o;
  logic                      wb_we_o;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    input  wb_ack_i, wb_err_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
    output wb_ack_i, wb_err_i, wb_dat_i
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Show-ahead synchronous FIFO with flush; head reads zero when empty.
module prefetch_fifo import fetch_pkg::*; #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] wr_en;

  // A flush wins over any push or pop in the same cycle.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_reg != '0);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  // Storage write; entries carry no reset since count gates visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem[i] <= push_data;
    end
  end

  // Pointers wrap naturally over PTR_W bits; count disambiguates full/empty.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count     = count_reg;

endmodule

// File: rtl/instr_fetch_prefetch.sv
// Prefetching fetch unit: Wishbone classic reads into a show-ahead FIFO,
// redirect flush with in-flight discard, and bus-error halt.
module instr_fetch_prefetch import fetch_pkg::*; #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  out_fault,
  instr_fetch_prefetch_if.master wb
);

  localparam int                    BYTES      = DATA_WIDTH / 8;
  localparam int                    FIFO_W     = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int                    CNT_W      = ptr_width(DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

  fetch_state_t          state_reg, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic                  discard_reg, discard_next;

  logic                  push;
  logic [FIFO_W-1:0]     push_data;
  logic                  pop;
  logic [FIFO_W-1:0]     head_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  bus_done;
  logic                  room_after_push;
  logic                  room_no_push;

  assign bus_done = (state_reg == FETCH) && (wb.wb_ack_i || wb.wb_err_i);
  // A pop coinciding with a redirect is lost in the flush anyway.
  assign pop      = out_valid && out_ready && !redirect_valid;

  // Room for another fetch once this cycle's push/pop have been applied.
  assign room_after_push = (int'(fifo_count) + 1 - int'(pop)) < DEPTH;
  assign room_no_push    = (int'(fifo_count) - int'(pop)) < DEPTH;

  prefetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      adr_reg      <= '0;
      discard_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      adr_reg      <= adr_next;
      discard_reg  <= discard_next;
    end
  end

  // Next-state, fetch address and FIFO push decisions; redirect has priority.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    adr_next      = adr_reg;
    discard_next  = discard_reg;
    push          = 1'b0;
    push_data     = '0;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & ALIGN_MASK;
      case (state_reg)
        FETCH: begin
          if (bus_done) begin
            state_next   = IDLE;
            discard_next = 1'b0;
          end else begin
            discard_next = 1'b1;
          end
        end
        HALT:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else begin
      case (state_reg)
        IDLE: begin
          if (fifo_count < CNT_W'(DEPTH)) begin
            state_next = FETCH;
            adr_next   = fetch_pc_reg;
          end
        end
        FETCH: begin
          if (bus_done) begin
            if (discard_reg) begin
              discard_next = 1'b0;
              if (room_no_push) adr_next = fetch_pc_reg;
              else              state_next = IDLE;
            end else if (wb.wb_ack_i) begin
              push          = 1'b1;
              push_data     = {1'b0, fetch_pc_reg, wb.wb_dat_i};
              fetch_pc_next = fetch_pc_reg + PC_INC;
              if (room_after_push) adr_next = fetch_pc_reg + PC_INC;
              else                 state_next = IDLE;
            end else begin
              push       = 1'b1;
              push_data  = {1'b1, fetch_pc_reg, {DATA_WIDTH{1'b0}}};
              state_next = HALT;
            end
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  assign wb.wb_cyc_o = (state_reg == FETCH);
  assign wb.wb_stb_o = (state_reg == FETCH);
  assign wb.wb_adr_o = adr_reg;
  assign wb.wb_sel_o = {BYTES{state_reg == FETCH}};
  assign wb.wb_dat_o = '0;
  assign wb.wb_we_o  = 1'b0;

  assign out_valid = (fifo_count != '0);
  assign {out_fault, out_pc, out_instr} = head_data;

endmodule
